// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the request state encoding, the fetch-entry layout and PC helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  localparam int unsigned     DATA_W           = 32;
  localparam logic [31:0]     INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0]     PC_STEP          = 32'd4;
  localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [31:0]       pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {instr, pc} pair that arrives
// while decode is stalled; clear wins over push and pop.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  fetch_entry_t entry_p0;
  logic         full_p0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_p0 <= 1'b0;
    end else if (push) begin
      full_p0 <= 1'b1;
    end else if (pop) begin
      full_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_p0 <= din;
    end
  end

  assign dout = entry_p0;
  assign full = full_p0;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding memory port, PC/redirect
// handling and a decode-facing output register backed by a skid entry.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] pc_address,
  output logic        valid
);

  fetch_state_e state_q, state_d;

  logic [31:0]       fetch_pc_p0;
  logic [31:0]       inflight_pc_p1;
  logic [DATA_W-1:0] instr_p2;
  logic [31:0]       pc_p2;
  logic              vld_p2;

  logic         issue_ok;
  logic         fire;
  logic         resp_kept;
  logic         out_free;
  logic         skid_push;
  logic         skid_pop;
  logic         skid_full;
  fetch_entry_t skid_din;
  fetch_entry_t skid_dout;

  always_comb begin
    out_free  = !vld_p2 || !stall;
    resp_kept = (state_q == S_WAIT) && imem_rvalid && !redirect_en;
    issue_ok  = (state_q == S_ISSUE) || ((state_q == S_WAIT) && imem_rvalid);
    imem_req  = !rst && !redirect_en && !skid_full && !(vld_p2 && stall) && issue_ok;
    fire      = imem_req && imem_gnt;
    skid_push = resp_kept && !out_free;
    skid_pop  = !redirect_en && !stall && skid_full;
  end

  assign imem_addr = fetch_pc_p0;

  // A redirect with the response in the same cycle leaves nothing pending,
  // so it returns straight to S_ISSUE instead of passing through S_DROP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ISSUE: begin
        if (fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_en) begin
          state_d = imem_rvalid ? S_ISSUE : S_DROP;
        end else if (imem_rvalid) begin
          state_d = fire ? S_WAIT : S_ISSUE;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p0: fetch PC
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_p0 <= RESET_PC;
    end else if (redirect_en) begin
      fetch_pc_p0 <= align_word(redirect_pc);
    end else if (fire) begin
      fetch_pc_p0 <= fetch_pc_p0 + PC_STEP;
    end
  end

  // Stage p1: address of the request in flight
  always_ff @(posedge clk) begin
    if (fire) begin
      inflight_pc_p1 <= fetch_pc_p0;
    end
  end

  assign skid_din = '{instr: imem_rdata, pc: inflight_pc_p1};

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .clear (redirect_en),
    .din   (skid_din),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  // Stage p2: decode-facing output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= INSTR_NOP;
      pc_p2    <= RESET_PC;
    end else if (redirect_en) begin
      vld_p2   <= 1'b0;
      instr_p2 <= INSTR_NOP;
    end else if (!stall) begin
      if (skid_full) begin
        vld_p2   <= 1'b1;
        instr_p2 <= skid_dout.instr;
        pc_p2    <= skid_dout.pc;
      end else if (resp_kept) begin
        vld_p2   <= 1'b1;
        instr_p2 <= imem_rdata;
        pc_p2    <= inflight_pc_p1;
      end else begin
        vld_p2   <= 1'b0;
        instr_p2 <= INSTR_NOP;
      end
    end else if (!vld_p2 && resp_kept) begin
      vld_p2   <= 1'b1;
      instr_p2 <= imem_rdata;
      pc_p2    <= inflight_pc_p1;
    end
  end

  assign instruction = instr_p2;
  assign pc_address  = pc_p2;
  assign valid       = vld_p2;

endmodule

// File: tb/tb_fetch.sv
// Randomised bench for the fetch stage: memory responder, in-order
// scoreboard on consumed instructions, plus directed scenario tasks.
module tb_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] PC_A = 32'h0000_0000;
  localparam logic [31:0] PC_B = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;

  logic        req_a, req_b, vld_a, vld_b;
  logic [31:0] addr_a, addr_b, instr_a, instr_b, pc_a, pc_b;

  logic        act_req, act_valid;
  logic [31:0] act_addr, act_instr, act_pc;

  int          vectors = 0;
  int          miscompares = 0;
  bit          sel = 1'b0;
  bit          gnt_rand = 1'b0;
  int          lat_lo = 1, lat_hi = 1;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr;
  int          mem_cnt = 0;
  logic [31:0] exp_pc = PC_A;
  int          consumed = 0;
  bit          prev_hold = 1'b0;
  bit          prev_sel = 1'b0;
  logic [31:0] prev_instr, prev_pc;

  fetch #(.RESET_PC(PC_A)) u_dut_a (
    .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .stall(stall), .instruction(instr_a),
    .pc_address(pc_a), .valid(vld_a));

  fetch #(.RESET_PC(PC_B)) u_dut_b (
    .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .stall(stall), .instruction(instr_b),
    .pc_address(pc_b), .valid(vld_b));

  always #5 clk = ~clk;

  assign act_req   = sel ? req_b   : req_a;
  assign act_addr  = sel ? addr_b  : addr_a;
  assign act_valid = sel ? vld_b   : vld_a;
  assign act_instr = sel ? instr_b : instr_a;
  assign act_pc    = sel ? pc_b    : pc_a;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  function automatic logic [31:0] base_pc();
    return sel ? PC_B : PC_A;
  endfunction

  // One clock: sample and score at the falling edge, then drive memory after the rise.
  task automatic tick();
    bit fire;
    @(negedge clk);
    fire = act_req && imem_gnt;
    if (act_req) begin
      vectors++;
      if (mem_busy && !imem_rvalid) begin
        miscompares++;
        $display("FAIL one_outstanding: req=1 with a request pending at %h", act_addr);
      end
      vectors++;
      if (act_addr[1:0] !== 2'b00) begin
        miscompares++;
        $display("FAIL addr_align: got %h want low bits 00", act_addr);
      end
    end
    if (act_valid === 1'b1 && stall && !rst) begin
      vectors++;
      if (act_req !== 1'b0) begin
        miscompares++;
        $display("FAIL req_while_stalled: got %b want 0", act_req);
      end
    end
    if (prev_hold && prev_sel == sel) begin
      vectors++;
      if (act_valid !== 1'b1 || act_instr !== prev_instr || act_pc !== prev_pc) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 act_valid, act_pc, act_instr, prev_pc, prev_instr);
      end
    end
    if (rst) begin
      exp_pc = base_pc();
    end else if (redirect_en) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (act_valid === 1'b1 && !stall) begin
      vectors++;
      if (act_pc !== exp_pc || act_instr !== mem_word(exp_pc)) begin
        miscompares++;
        $display("FAIL scoreboard: got pc=%h i=%h want pc=%h i=%h",
                 act_pc, act_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (imem_rvalid) mem_busy = 1'b0;
    if (fire) begin
      mem_busy = 1'b1;
      mem_addr = act_addr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
    end
    prev_hold  = (act_valid === 1'b1) && stall && !redirect_en && !rst;
    prev_sel   = sel;
    prev_instr = act_instr;
    prev_pc    = act_pc;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
    imem_gnt = gnt_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1;
    repeat (3) tick();
    vectors++;
    if (act_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", act_valid); end
    vectors++;
    if (act_instr !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h want %h", act_instr, NOP); end
    vectors++;
    if (act_pc !== base_pc()) begin miscompares++; $display("FAIL reset_pc: got %h want %h", act_pc, base_pc()); end
    vectors++;
    if (act_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", act_req); end
    rst = 1'b0;
    #1;
    vectors++;
    if (act_req !== 1'b1 || act_addr !== base_pc()) begin
      miscompares++;
      $display("FAIL first_issue: got req=%b addr=%h want req=1 addr=%h", act_req, act_addr, base_pc());
    end
  endtask

  task automatic test_stream();
    tick();
    vectors++;
    if (act_valid !== 1'b0) begin miscompares++; $display("FAIL stream_cycle1: got valid %b want 0", act_valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (act_valid !== 1'b1 || act_pc !== 32'(4 * k) || act_instr !== mem_word(32'(4 * k))) begin
        miscompares++;
        $display("FAIL stream_pc%0d: got v=%b pc=%h want v=1 pc=%h", k, act_valid, act_pc, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_instr;
    bit ok;
    held_pc = act_pc; held_instr = act_instr;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (act_req !== 1'b0) begin miscompares++; $display("FAIL stall_req%0d: got %b want 0", i, act_req); end
      tick();
      vectors++;
      if (act_valid !== 1'b1 || act_pc !== held_pc || act_instr !== held_instr) begin
        miscompares++;
        $display("FAIL stall_frozen%0d: got pc=%h want pc=%h", i, act_pc, held_pc);
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (act_valid !== 1'b1 || act_pc !== held_pc + 32'd4 || act_instr !== mem_word(held_pc + 32'd4)) begin
      miscompares++;
      $display("FAIL skid_release: got v=%b pc=%h want v=1 pc=%h", act_valid, act_pc, held_pc + 32'd4);
    end
    tick();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (act_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok || act_pc !== held_pc + 32'd8) begin
      miscompares++;
      $display("FAIL stall_resume: got ok=%b pc=%h want pc=%h", ok, act_pc, held_pc + 32'd8);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    lat_lo = 3; lat_hi = 3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (act_req && imem_gnt) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL redir_setup: got no issue want one within 20 cycles"); end
    tick();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0102;
    #1;
    vectors++;
    if (act_req !== 1'b0) begin miscompares++; $display("FAIL redir_no_req: got %b want 0", act_req); end
    tick();
    redirect_en = 1'b0;
    #1;
    vectors++;
    if (act_addr !== 32'h100 || act_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_addr: got addr=%h v=%b want addr=00000100 v=0", act_addr, act_valid);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (act_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok || act_pc !== 32'h100 || act_instr !== mem_word(32'h100)) begin
      miscompares++;
      $display("FAIL redir_first: got ok=%b pc=%h want pc=00000100", ok, act_pc);
    end
  endtask

  task automatic test_redirect_rvalid();
    bit ok, seen;
    logic [31:0] first_fire;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_rvalid) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rv_setup: got no rvalid want one within 20 cycles"); end
    redirect_en = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_en = 1'b0;
    #1;
    vectors++;
    if (act_req !== 1'b1 || act_addr !== 32'h200 || act_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rv_reissue: got req=%b addr=%h v=%b want req=1 addr=00000200 v=0", act_req, act_addr, act_valid);
    end
    tick();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0405;
    #1;
    vectors++;
    if (act_req !== 1'b0 || act_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_quiet: got req=%b v=%b want req=0 v=0", act_req, act_valid);
    end
    tick();
    redirect_en = 1'b0;
    ok = 1'b0; seen = 1'b0; first_fire = '0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (act_valid === 1'b1) begin ok = 1'b1; break; end
      if (act_req && imem_gnt && !seen) begin seen = 1'b1; first_fire = act_addr; end
      tick();
    end
    vectors++;
    if (!seen || first_fire !== 32'h404) begin
      miscompares++;
      $display("FAIL last_target_fetch: got %h want 00000404", first_fire);
    end
    vectors++;
    if (!ok || act_pc !== 32'h404 || act_instr !== mem_word(32'h404)) begin
      miscompares++;
      $display("FAIL last_target_valid: got ok=%b pc=%h want pc=00000404", ok, act_pc);
    end
  endtask

  task automatic test_random();
    int c0;
    c0 = consumed;
    gnt_rand = 1'b1; lat_lo = 1; lat_hi = 6;
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 9) < 3);
      redirect_en = ($urandom_range(0, 49) == 0);
      redirect_pc = $urandom;
      tick();
    end
    stall = 1'b0; redirect_en = 1'b0;
    repeat (30) tick();
    vectors++;
    if (consumed - c0 < 100) begin
      miscompares++;
      $display("FAIL random_progress: got %0d instructions want at least 100", consumed - c0);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] pcs [3];
    int n;
    bit ok;
    sel = 1'b1; rst = 1'b1; stall = 1'b0; redirect_en = 1'b0;
    gnt_rand = 1'b0; lat_lo = 1; lat_hi = 1;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (act_addr !== PC_B || act_pc !== PC_B) begin
      miscompares++;
      $display("FAIL wrap_reset_pc: got addr=%h pc=%h want %h", act_addr, act_pc, PC_B);
    end
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick();
      if (act_valid === 1'b1) begin pcs[n] = act_pc; n++; end
    end
    vectors++;
    if (n != 3 || pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_seq: got n=%0d %h %h %h want FFFFFFF8 FFFFFFFC 00000000", n, pcs[0], pcs[1], pcs[2]);
    end
    lat_lo = 3; lat_hi = 3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (act_req && imem_gnt) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    rst = 1'b1;
    repeat (5) tick();
    lat_lo = 1; lat_hi = 1;
    rst = 1'b0;
    #1;
    vectors++;
    if (!ok || act_valid !== 1'b0 || act_addr !== PC_B) begin
      miscompares++;
      $display("FAIL midwait_reset: got ok=%b v=%b addr=%h want v=0 addr=%h", ok, act_valid, act_addr, PC_B);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (act_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!ok || act_pc !== PC_B || act_instr !== mem_word(PC_B)) begin
      miscompares++;
      $display("FAIL midwait_restart: got ok=%b pc=%h want pc=%h", ok, act_pc, PC_B);
    end
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_en = 1'b0; redirect_pc = '0; stall = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_random();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
